// File: rtl/sv_ifq_pkg.sv
// Shared types and helpers for the qualified if-chain monitor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: mode/kind enums, fixed violation-record header, popcount helper.
package sv_ifq_pkg;

   // Widest condition vector the monitor supports; popcount works on this width.
   localparam int COND_MAX = 16;
   localparam int PC_W     = $clog2(COND_MAX + 1);

   typedef enum logic [1:0] {
      MODE_PLAIN    = 2'd0,
      MODE_UNIQUE   = 2'd1,
      MODE_UNIQUE0  = 2'd2,
      MODE_PRIORITY = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      KIND_NONE     = 2'd0,
      KIND_NO_MATCH = 2'd1,
      KIND_OVERLAP  = 2'd2
   } kind_e;

   // Parameter-independent part of a violation record. The timestamp and
   // condition vector depend on module parameters, so the full record wraps
   // this header inside the top module.
   typedef struct packed {
      kind_e kind;
      mode_e mode;
   } viol_hdr_t;

   function automatic logic [PC_W-1:0] popcount(input logic [COND_MAX-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < COND_MAX; i++) begin
         n = n + {{(PC_W-1){1'b0}}, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/sv_if_qualifier_monitor_if.sv
// Bus bundle between the instrumented if-chain source and the monitor.
// Latency: n/a (wires only).
// Backpressure: rpt_valid/rpt_ready handshake on the violation-record side.
// master = instrumentation/reporter side, slave = monitor side.
interface sv_if_qualifier_monitor_if #(
   parameter int N_COND = 4,
   parameter int TS_W   = 16,
   parameter int CNT_W  = 16
);
   localparam int IDX_W = $clog2(N_COND);

   logic              eval_valid;
   logic [1:0]        eval_mode;
   logic              eval_has_else;
   logic [N_COND-1:0] eval_cond;

   logic              sel_valid;
   logic [IDX_W-1:0]  sel_idx;
   logic              sel_else;
   logic              sel_none;
   logic              viol_pulse;

   logic              rpt_valid;
   logic              rpt_ready;
   logic [1:0]        rpt_kind;
   logic [1:0]        rpt_mode;
   logic [TS_W-1:0]   rpt_ts;
   logic [N_COND-1:0] rpt_cond;

   logic [CNT_W-1:0]  cnt_no_match;
   logic [CNT_W-1:0]  cnt_overlap;
   logic              dropped;

   modport master (
      output eval_valid, eval_mode, eval_has_else, eval_cond, rpt_ready,
      input  sel_valid, sel_idx, sel_else, sel_none, viol_pulse,
      input  rpt_valid, rpt_kind, rpt_mode, rpt_ts, rpt_cond,
      input  cnt_no_match, cnt_overlap, dropped
   );

   modport slave (
      input  eval_valid, eval_mode, eval_has_else, eval_cond, rpt_ready,
      output sel_valid, sel_idx, sel_else, sel_none, viol_pulse,
      output rpt_valid, rpt_kind, rpt_mode, rpt_ts, rpt_cond,
      output cnt_no_match, cnt_overlap, dropped
   );

endinterface

// File: rtl/sv_ifq_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers.
// Latency: 1 cycle write-to-read (no fall-through).
// Backpressure: wr_ready_o low only when full and not popping this cycle.
// Ports: clk/rst; wr_valid_i/wr_data_i/wr_ready_o; rd_valid_o/rd_ready_i/rd_data_o.
module sv_ifq_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic             wr_ready_o,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic [WIDTH-1:0] rd_data_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;

   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = !empty && rd_ready_i;
   // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
   assign wr_ready_o = !full || pop;
   assign push       = wr_valid_i && wr_ready_o;
   assign rd_valid_o = !empty;
   // Zero the head while empty so downstream sees clean data after reset.
   assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/sv_if_qualifier_monitor.sv
// Runtime checker for unique/unique0/priority if-chains: resolves branch, flags violations.
// Latency: 1 cycle eval->sel/viol_pulse; record visible at rpt_* 1 cycle after viol_pulse.
// Backpressure: rpt_ready stalls the record FIFO; overflow drops records and sets sticky dropped.
// Ports: clk, rst (sync, active-high), bus (slave modport: eval_*, sel_*, viol_pulse, rpt_*, counters).
module sv_if_qualifier_monitor
   import sv_ifq_pkg::*;
#(
   parameter int N_COND     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16,
   parameter int TS_W       = 16
) (
   input logic                       clk,
   input logic                       rst,
   sv_if_qualifier_monitor_if.slave  bus
);
   localparam int IDX_W = $clog2(N_COND);

   typedef struct packed {
      viol_hdr_t         hdr;
      logic [TS_W-1:0]   ts;
      logic [N_COND-1:0] cond;
   } rec_t;

   localparam int REC_W = $bits(rec_t);

   // Resolution / classification (combinational on the presented evaluation)
   logic [IDX_W-1:0]    sel_idx_d;
   logic                any_d;
   logic [COND_MAX-1:0] cond_ext;
   logic [PC_W-1:0]     pc_d;
   mode_e               mode_d;
   kind_e               kind_d;
   rec_t                rec_d;

   // Registered state
   logic [TS_W-1:0]     ts_q;
   logic                sel_valid_q;
   logic [IDX_W-1:0]    sel_idx_q;
   logic                sel_else_q;
   logic                sel_none_q;
   logic                viol_pulse_q;
   rec_t                rec_q;
   logic [CNT_W-1:0]    cnt_no_match_q;
   logic [CNT_W-1:0]    cnt_overlap_q;
   logic                dropped_q;

   // FIFO side
   logic                fifo_wr_ready;
   logic                fifo_rd_valid;
   rec_t                fifo_rd_dat;

   always_comb begin
      // Scan from the top so the lowest set index is the one left standing.
      sel_idx_d = '0;
      for (int i = N_COND - 1; i >= 0; i--) begin
         if (bus.eval_cond[i]) sel_idx_d = IDX_W'(i);
      end
      any_d                = |bus.eval_cond;
      cond_ext             = '0;
      cond_ext[N_COND-1:0] = bus.eval_cond;
      pc_d                 = popcount(cond_ext);
      mode_d               = mode_e'(bus.eval_mode);

      // OVERLAP needs two or more true conditions and NO_MATCH needs none,
      // so at most one kind can ever be raised.
      kind_d = KIND_NONE;
      case (mode_d)
         MODE_UNIQUE: begin
            if (pc_d > PC_W'(1))                   kind_d = KIND_OVERLAP;
            else if (!any_d && !bus.eval_has_else) kind_d = KIND_NO_MATCH;
         end
         MODE_UNIQUE0: begin
            if (pc_d > PC_W'(1))                   kind_d = KIND_OVERLAP;
         end
         MODE_PRIORITY: begin
            if (!any_d && !bus.eval_has_else)      kind_d = KIND_NO_MATCH;
         end
         default: kind_d = KIND_NONE;
      endcase

      rec_d.hdr.kind = kind_d;
      rec_d.hdr.mode = mode_d;
      rec_d.ts       = ts_q;
      rec_d.cond     = bus.eval_cond;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q           <= '0;
         sel_valid_q    <= 1'b0;
         sel_idx_q      <= '0;
         sel_else_q     <= 1'b0;
         sel_none_q     <= 1'b0;
         viol_pulse_q   <= 1'b0;
         rec_q          <= '0;
         cnt_no_match_q <= '0;
         cnt_overlap_q  <= '0;
         dropped_q      <= 1'b0;
      end else begin
         ts_q         <= ts_q + 1'b1;
         sel_valid_q  <= bus.eval_valid;
         viol_pulse_q <= bus.eval_valid && (kind_d != KIND_NONE);

         // sel_* hold their last resolution between evaluations.
         if (bus.eval_valid) begin
            sel_idx_q  <= sel_idx_d;
            sel_else_q <= !any_d && bus.eval_has_else;
            sel_none_q <= !any_d && !bus.eval_has_else;
            rec_q      <= rec_d;
         end

         // Counters step on the same edge that raises viol_pulse, whether or
         // not the record later fits in the FIFO.
         if (bus.eval_valid && (kind_d == KIND_NO_MATCH) && (cnt_no_match_q != '1)) begin
            cnt_no_match_q <= cnt_no_match_q + 1'b1;
         end
         if (bus.eval_valid && (kind_d == KIND_OVERLAP) && (cnt_overlap_q != '1)) begin
            cnt_overlap_q <= cnt_overlap_q + 1'b1;
         end

         if (viol_pulse_q && !fifo_wr_ready) begin
            dropped_q <= 1'b1;
         end
      end
   end

   // The record is written during its viol_pulse cycle.
   sv_ifq_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_valid_i (viol_pulse_q),
      .wr_data_i  (rec_q),
      .wr_ready_o (fifo_wr_ready),
      .rd_valid_o (fifo_rd_valid),
      .rd_ready_i (bus.rpt_ready),
      .rd_data_o  (fifo_rd_dat)
   );

   assign bus.sel_valid    = sel_valid_q;
   assign bus.sel_idx      = sel_idx_q;
   assign bus.sel_else     = sel_else_q;
   assign bus.sel_none     = sel_none_q;
   assign bus.viol_pulse   = viol_pulse_q;
   assign bus.rpt_valid    = fifo_rd_valid;
   assign bus.rpt_kind     = fifo_rd_dat.hdr.kind;
   assign bus.rpt_mode     = fifo_rd_dat.hdr.mode;
   assign bus.rpt_ts       = fifo_rd_dat.ts;
   assign bus.rpt_cond     = fifo_rd_dat.cond;
   assign bus.cnt_no_match = cnt_no_match_q;
   assign bus.cnt_overlap  = cnt_overlap_q;
   assign bus.dropped      = dropped_q;

endmodule

// File: tb/tb_sv_if_qualifier_monitor.sv
// Self-checking bench for sv_if_qualifier_monitor: directed scenarios plus a
// randomized run against a queue-based reference model. A second instance with
// 2-bit counters shares the stimulus to exercise counter saturation.
`timescale 1ns/1ps
module tb_sv_if_qualifier_monitor;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   sv_if_qualifier_monitor_if #(.N_COND(4), .TS_W(16), .CNT_W(16)) ifm ();
   sv_if_qualifier_monitor_if #(.N_COND(4), .TS_W(16), .CNT_W(2))  ifs ();

   sv_if_qualifier_monitor #(.N_COND(4), .FIFO_DEPTH(DEPTH), .CNT_W(16), .TS_W(16)) dut (
      .clk(clk), .rst(rst), .bus(ifm));
   sv_if_qualifier_monitor #(.N_COND(4), .FIFO_DEPTH(DEPTH), .CNT_W(2), .TS_W(16)) dut_sat (
      .clk(clk), .rst(rst), .bus(ifs));

   assign ifs.eval_valid    = ifm.eval_valid;
   assign ifs.eval_mode     = ifm.eval_mode;
   assign ifs.eval_has_else = ifm.eval_has_else;
   assign ifs.eval_cond     = ifm.eval_cond;
   assign ifs.rpt_ready     = ifm.rpt_ready;

   // ---------------- reference model ----------------
   typedef struct { int kind; int mode; int ts; logic [3:0] cond; } rec_s;
   rec_s       mq[$];
   rec_s       pend;
   bit         pend_v;
   int         m_ts, m_nm, m_ov, m_pc, m_kind, m_idx;
   bit         m_drop, m_sv, m_else, m_none, m_pop;
   logic [3:0] m_low;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         pend_v = 0; m_ts = 0; m_nm = 0; m_ov = 0; m_drop = 0;
         m_sv = 0; m_idx = 0; m_else = 0; m_none = 0;
      end else begin
         m_pop = (mq.size() > 0) && (ifm.rpt_ready === 1'b1);
         if (m_pop) mq.delete(0);
         if (pend_v) begin
            if (mq.size() < DEPTH) mq.push_back(pend);
            else m_drop = 1;
         end
         pend_v = 0;
         m_sv = ifm.eval_valid;
         if (ifm.eval_valid) begin
            m_pc  = $countones(ifm.eval_cond);
            m_low = ifm.eval_cond & (~ifm.eval_cond + 4'd1);   // isolate lowest set bit
            m_idx = (m_low == 4'd2) ? 1 : (m_low == 4'd4) ? 2 : (m_low == 4'd8) ? 3 : 0;
            m_else = (m_pc == 0) && ifm.eval_has_else;
            m_none = (m_pc == 0) && !ifm.eval_has_else;
            case (ifm.eval_mode)
               2'd1:    m_kind = (m_pc > 1) ? 2 : ((m_pc == 0 && !ifm.eval_has_else) ? 1 : 0);
               2'd2:    m_kind = (m_pc > 1) ? 2 : 0;
               2'd3:    m_kind = (m_pc == 0 && !ifm.eval_has_else) ? 1 : 0;
               default: m_kind = 0;
            endcase
            if (m_kind != 0) begin
               pend_v = 1;
               pend.kind = m_kind; pend.mode = int'(ifm.eval_mode);
               pend.ts = m_ts; pend.cond = ifm.eval_cond;
               if (m_kind == 1) m_nm++; else m_ov++;
            end
         end
         m_ts = (m_ts + 1) % 65536;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit v, input int mode, input bit he, input logic [3:0] c, input bit rdy);
      ifm.eval_valid = v; ifm.eval_mode = 2'(mode); ifm.eval_has_else = he;
      ifm.eval_cond = c; ifm.rpt_ready = rdy;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; drive(0, 0, 0, 4'd0, 0); tick(); rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; drive(1, 1, 0, 4'b0011, 1);
      tick(); tick();
      checks++; if (ifm.sel_valid !== 1'b0) begin errors++; $display("FAIL reset_sel_valid got=%0d exp=0", ifm.sel_valid); end
      checks++; if (ifm.sel_idx !== 2'd0) begin errors++; $display("FAIL reset_sel_idx got=%0d exp=0", ifm.sel_idx); end
      checks++; if (ifm.viol_pulse !== 1'b0) begin errors++; $display("FAIL reset_viol got=%0d exp=0", ifm.viol_pulse); end
      checks++; if (ifm.rpt_valid !== 1'b0) begin errors++; $display("FAIL reset_rpt_valid got=%0d exp=0", ifm.rpt_valid); end
      checks++; if (ifm.cnt_overlap !== 16'd0) begin errors++; $display("FAIL reset_cnt_ov got=%0d exp=0", ifm.cnt_overlap); end
      checks++; if (ifm.dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped got=%0d exp=0", ifm.dropped); end
      rst = 1'b0; drive(0, 0, 0, 4'd0, 0); tick();
   endtask

   task automatic test_unique();
      do_reset();
      drive(1, 1, 1, 4'b0001, 1); tick();
      checks++; if (ifm.sel_valid !== 1'b1) begin errors++; $display("FAIL uniq_sel_valid got=%0d exp=1", ifm.sel_valid); end
      checks++; if (ifm.sel_idx !== 2'd0) begin errors++; $display("FAIL uniq_sel_idx got=%0d exp=0", ifm.sel_idx); end
      checks++; if (ifm.sel_else !== 1'b0) begin errors++; $display("FAIL uniq_sel_else got=%0d exp=0", ifm.sel_else); end
      checks++; if (ifm.viol_pulse !== 1'b0) begin errors++; $display("FAIL uniq_viol got=%0d exp=0", ifm.viol_pulse); end
      drive(1, 1, 1, 4'b0000, 1); tick();
      checks++; if (ifm.sel_else !== 1'b1) begin errors++; $display("FAIL uniq_else_taken got=%0d exp=1", ifm.sel_else); end
      checks++; if (ifm.sel_none !== 1'b0) begin errors++; $display("FAIL uniq_else_none got=%0d exp=0", ifm.sel_none); end
      checks++; if (ifm.viol_pulse !== 1'b0) begin errors++; $display("FAIL uniq_else_viol got=%0d exp=0", ifm.viol_pulse); end
      drive(0, 0, 0, 4'd0, 1); tick();
      checks++; if (ifm.sel_valid !== 1'b0) begin errors++; $display("FAIL uniq_idle_valid got=%0d exp=0", ifm.sel_valid); end
      checks++; if (ifm.sel_else !== 1'b1) begin errors++; $display("FAIL uniq_hold_else got=%0d exp=1", ifm.sel_else); end
   endtask

   task automatic test_unique0();
      int t0;
      do_reset();
      drive(1, 2, 0, 4'b0000, 1); tick();
      checks++; if (ifm.sel_none !== 1'b1) begin errors++; $display("FAIL u0_sel_none got=%0d exp=1", ifm.sel_none); end
      checks++; if (ifm.viol_pulse !== 1'b0) begin errors++; $display("FAIL u0_empty_viol got=%0d exp=0", ifm.viol_pulse); end
      drive(1, 2, 0, 4'b1100, 1); t0 = m_ts; tick();
      checks++; if (ifm.sel_idx !== 2'd2) begin errors++; $display("FAIL u0_sel_idx got=%0d exp=2", ifm.sel_idx); end
      checks++; if (ifm.viol_pulse !== 1'b1) begin errors++; $display("FAIL u0_viol got=%0d exp=1", ifm.viol_pulse); end
      checks++; if (ifm.cnt_overlap !== 16'd1) begin errors++; $display("FAIL u0_cnt_ov got=%0d exp=1", ifm.cnt_overlap); end
      drive(0, 0, 0, 4'd0, 1);
      checks++; if (ifm.rpt_valid !== 1'b0) begin errors++; $display("FAIL u0_no_fallthrough got=%0d exp=0", ifm.rpt_valid); end
      tick();
      checks++; if (ifm.rpt_valid !== 1'b1) begin errors++; $display("FAIL u0_rpt_valid got=%0d exp=1", ifm.rpt_valid); end
      checks++; if (ifm.rpt_kind !== 2'd2) begin errors++; $display("FAIL u0_rpt_kind got=%0d exp=2", ifm.rpt_kind); end
      checks++; if (ifm.rpt_mode !== 2'd2) begin errors++; $display("FAIL u0_rpt_mode got=%0d exp=2", ifm.rpt_mode); end
      checks++; if (ifm.rpt_cond !== 4'b1100) begin errors++; $display("FAIL u0_rpt_cond got=%b exp=1100", ifm.rpt_cond); end
      checks++; if (ifm.rpt_ts !== 16'(t0)) begin errors++; $display("FAIL u0_rpt_ts got=%0d exp=%0d", ifm.rpt_ts, t0); end
      tick();
   endtask

   task automatic test_priority();
      do_reset();
      drive(1, 3, 1, 4'b0011, 1); tick();
      checks++; if (ifm.sel_idx !== 2'd0) begin errors++; $display("FAIL prio_sel_idx got=%0d exp=0", ifm.sel_idx); end
      checks++; if (ifm.viol_pulse !== 1'b0) begin errors++; $display("FAIL prio_overlap_viol got=%0d exp=0", ifm.viol_pulse); end
      drive(1, 3, 0, 4'b0000, 1); tick();
      checks++; if (ifm.sel_none !== 1'b1) begin errors++; $display("FAIL prio_sel_none got=%0d exp=1", ifm.sel_none); end
      checks++; if (ifm.viol_pulse !== 1'b1) begin errors++; $display("FAIL prio_viol got=%0d exp=1", ifm.viol_pulse); end
      checks++; if (ifm.cnt_no_match !== 16'd1) begin errors++; $display("FAIL prio_cnt_nm got=%0d exp=1", ifm.cnt_no_match); end
      checks++; if (ifm.cnt_overlap !== 16'd0) begin errors++; $display("FAIL prio_cnt_ov got=%0d exp=0", ifm.cnt_overlap); end
      drive(0, 0, 0, 4'd0, 1); tick();
      checks++; if (ifm.rpt_kind !== 2'd1) begin errors++; $display("FAIL prio_rpt_kind got=%0d exp=1", ifm.rpt_kind); end
      tick();
   endtask

   task automatic test_overflow();
      int ts[5];
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1, 1, 1, 4'b0110, 0); ts[k] = m_ts; tick();
      end
      drive(0, 0, 0, 4'd0, 0); tick(); tick();
      checks++; if (ifm.dropped !== 1'b1) begin errors++; $display("FAIL ovf_dropped got=%0d exp=1", ifm.dropped); end
      checks++; if (ifm.cnt_overlap !== 16'd5) begin errors++; $display("FAIL ovf_cnt_ov got=%0d exp=5", ifm.cnt_overlap); end
      checks++; if (ifs.cnt_overlap !== 2'd3) begin errors++; $display("FAIL sat_cnt_ov got=%0d exp=3", ifs.cnt_overlap); end
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 4'd0, 1);
         checks++; if (ifm.rpt_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain_valid[%0d] got=%0d exp=1", k, ifm.rpt_valid); end
         checks++; if (ifm.rpt_ts !== 16'(ts[k])) begin errors++; $display("FAIL ovf_drain_ts[%0d] got=%0d exp=%0d", k, ifm.rpt_ts, ts[k]); end
         checks++; if (ifm.rpt_kind !== 2'd2) begin errors++; $display("FAIL ovf_drain_kind[%0d] got=%0d exp=2", k, ifm.rpt_kind); end
         tick();
      end
      checks++; if (ifm.rpt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%0d exp=0", ifm.rpt_valid); end
   endtask

   task automatic test_full_pop();
      int ts[5];
      int n;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1, 1, 1, 4'b1010, 0); ts[k] = m_ts; tick();
      end
      // FIFO now full and the 5th record is in its write cycle: pop alongside it.
      drive(0, 0, 0, 4'd0, 1); tick();
      drive(0, 0, 0, 4'd0, 0);
      checks++; if (ifm.dropped !== 1'b0) begin errors++; $display("FAIL fullpop_dropped got=%0d exp=0", ifm.dropped); end
      checks++; if (ifm.rpt_ts !== 16'(ts[1])) begin errors++; $display("FAIL fullpop_head_ts got=%0d exp=%0d", ifm.rpt_ts, ts[1]); end
      tick();
      n = 0;
      drive(0, 0, 0, 4'd0, 1);
      for (int i = 0; i < 8; i++) begin
         if (ifm.rpt_valid === 1'b1) begin
            if (n < 4) begin
               checks++; if (ifm.rpt_ts !== 16'(ts[n+1])) begin errors++; $display("FAIL fullpop_ts[%0d] got=%0d exp=%0d", n, ifm.rpt_ts, ts[n+1]); end
            end
            n++;
         end
         tick();
      end
      checks++; if (n != 4) begin errors++; $display("FAIL fullpop_occupancy got=%0d exp=4", n); end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1, 1, 1, 4'b0110, 0); tick();
      end
      drive(0, 0, 0, 4'd0, 0); tick(); tick();
      drive(0, 0, 0, 4'd0, 1); tick();
      rst = 1'b1; drive(1, 1, 0, 4'b0111, 1); tick();
      rst = 1'b0; drive(0, 0, 0, 4'd0, 0);
      checks++; if (ifm.sel_valid !== 1'b0) begin errors++; $display("FAIL rstmid_sel_valid got=%0d exp=0", ifm.sel_valid); end
      checks++; if (ifm.sel_idx !== 2'd0) begin errors++; $display("FAIL rstmid_sel_idx got=%0d exp=0", ifm.sel_idx); end
      checks++; if (ifm.rpt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rpt_valid got=%0d exp=0", ifm.rpt_valid); end
      checks++; if (ifm.rpt_cond !== 4'd0) begin errors++; $display("FAIL rstmid_rpt_cond got=%b exp=0000", ifm.rpt_cond); end
      checks++; if (ifm.cnt_overlap !== 16'd0) begin errors++; $display("FAIL rstmid_cnt_ov got=%0d exp=0", ifm.cnt_overlap); end
      checks++; if (ifm.dropped !== 1'b0) begin errors++; $display("FAIL rstmid_dropped got=%0d exp=0", ifm.dropped); end
      checks++; if (ifs.cnt_overlap !== 2'd0) begin errors++; $display("FAIL rstmid_sat_cnt got=%0d exp=0", ifs.cnt_overlap); end
      tick();
      checks++; if (ifm.viol_pulse !== 1'b0) begin errors++; $display("FAIL rstmid_inflight_viol got=%0d exp=0", ifm.viol_pulse); end
      checks++; if (ifm.sel_valid !== 1'b0) begin errors++; $display("FAIL rstmid_inflight_sel got=%0d exp=0", ifm.sel_valid); end
   endtask

   task automatic test_random();
      int ek, em, et;
      logic [3:0] ec;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (mq.size() > 0) begin ek = mq[0].kind; em = mq[0].mode; et = mq[0].ts; ec = mq[0].cond; end
         else begin ek = 0; em = 0; et = 0; ec = 4'd0; end
         checks++; if (ifm.sel_valid !== m_sv) begin errors++; $display("FAIL rnd_sel_valid c=%0d got=%0d exp=%0d", cyc, ifm.sel_valid, m_sv); end
         checks++; if (ifm.sel_idx !== 2'(m_idx)) begin errors++; $display("FAIL rnd_sel_idx c=%0d got=%0d exp=%0d", cyc, ifm.sel_idx, m_idx); end
         checks++; if (ifm.sel_else !== m_else || ifm.sel_none !== m_none) begin errors++; $display("FAIL rnd_else_none c=%0d got=%0d/%0d exp=%0d/%0d", cyc, ifm.sel_else, ifm.sel_none, m_else, m_none); end
         checks++; if (ifm.viol_pulse !== pend_v) begin errors++; $display("FAIL rnd_viol c=%0d got=%0d exp=%0d", cyc, ifm.viol_pulse, pend_v); end
         checks++; if (ifm.rpt_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_rpt_valid c=%0d got=%0d exp=%0d", cyc, ifm.rpt_valid, mq.size() > 0); end
         checks++; if (ifm.rpt_kind !== 2'(ek) || ifm.rpt_mode !== 2'(em)) begin errors++; $display("FAIL rnd_rpt_kind_mode c=%0d got=%0d/%0d exp=%0d/%0d", cyc, ifm.rpt_kind, ifm.rpt_mode, ek, em); end
         checks++; if (ifm.rpt_ts !== 16'(et) || ifm.rpt_cond !== ec) begin errors++; $display("FAIL rnd_rpt_ts_cond c=%0d got=%0d/%b exp=%0d/%b", cyc, ifm.rpt_ts, ifm.rpt_cond, et, ec); end
         checks++; if (ifm.cnt_no_match !== 16'(m_nm) || ifm.cnt_overlap !== 16'(m_ov)) begin errors++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d", cyc, ifm.cnt_no_match, ifm.cnt_overlap, m_nm, m_ov); end
         checks++; if (ifs.cnt_no_match !== 2'((m_nm > 3) ? 3 : m_nm) || ifs.cnt_overlap !== 2'((m_ov > 3) ? 3 : m_ov)) begin errors++; $display("FAIL rnd_sat_cnt c=%0d got=%0d/%0d exp_raw=%0d/%0d", cyc, ifs.cnt_no_match, ifs.cnt_overlap, m_nm, m_ov); end
         checks++; if (ifm.dropped !== m_drop) begin errors++; $display("FAIL rnd_dropped c=%0d got=%0d exp=%0d", cyc, ifm.dropped, m_drop); end
         drive(($urandom % 4) != 0, int'($urandom % 4), 1'($urandom % 2),
               4'($urandom % 16), ($urandom % 3) == 0);
         tick();
      end
      drive(0, 0, 0, 4'd0, 0);
   endtask

   initial begin
      drive(0, 0, 0, 4'd0, 0);
      tick();
      test_reset();
      test_unique();
      test_unique0();
      test_priority();
      test_overflow();
      test_full_pop();
      test_reset_mid_drain();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
